// File: rtl/led_pkg.sv
// led_pkg: shared geometry and state encoding for the LED frame memory readers and writers.
package led_pkg;
    localparam int LED_WIDTH  = 10;
    localparam int LED_ROWS   = 4;
    localparam int LED_ADDR_W = $clog2(LED_ROWS);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_BLANK, S_DWELL, S_DONE} led_state_e;
endpackage

// File: rtl/led_dwell_timer.sv
// led_dwell_timer: loadable down-counter; tc is high on the last cycle of a loaded interval.
module led_dwell_timer #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (start) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign tc = cnt == W'(1);
endmodule

// File: rtl/led_frame_reader.sv
// led_frame_reader: snapshots the LED frame memory each frame, then scans rows onto the matrix
// with a dark blanking gap before every row's dwell.
module led_frame_reader
    import led_pkg::*;
#(
    parameter int WIDTH  = LED_WIDTH,
    parameter int ROWS   = LED_ROWS,
    parameter int RD_LAT = 1,
    parameter int DWELL  = 1000,
    parameter int BLANK  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [WIDTH-1:0]        mem_rd_data,
    output logic [$clog2(ROWS)-1:0] addr_rd,
    output logic                    fetch_busy,
    output logic [ROWS-1:0]         led_row,
    output logic [WIDTH-1:0]        led_col,
    output logic                    frame_done
);
    localparam int AW = $clog2(ROWS);
    localparam int CW = $clog2((DWELL > BLANK ? DWELL : BLANK) + 1);
    localparam int FL = ROWS + RD_LAT;
    localparam int FW = $clog2(FL + 1);

    led_state_e       state, nxt;
    logic [AW-1:0]    row, nxt_row;
    logic [FW-1:0]    fcnt;
    logic [WIDTH-1:0] shadow [ROWS];
    logic             tc, start, fetch_end, last_row;
    logic [CW-1:0]    load_val;

    assign fetch_end  = state == S_FETCH && fcnt == FW'(FL - 1);
    assign last_row   = row == AW'(ROWS - 1);
    assign fetch_busy = state == S_FETCH;
    assign frame_done = state == S_DONE;
    assign addr_rd    = !fetch_busy ? '0 : fcnt < FW'(ROWS) ? fcnt[AW-1:0] : AW'(ROWS - 1);
    assign load_val   = nxt == S_BLANK ? CW'(BLANK) : CW'(DWELL);

    // With BLANK=0 each row goes straight to its dwell.
    always_comb begin
        nxt     = state;
        nxt_row = row;
        start   = 1'b0;
        case (state)
            S_IDLE:  nxt = enable ? S_FETCH : S_IDLE;
            S_FETCH: if (fetch_end) begin
                nxt     = BLANK == 0 ? S_DWELL : S_BLANK;
                nxt_row = '0;
                start   = 1'b1;
            end
            S_BLANK: if (tc) begin
                nxt   = S_DWELL;
                start = 1'b1;
            end
            S_DWELL: if (tc) begin
                nxt     = last_row ? S_DONE : BLANK == 0 ? S_DWELL : S_BLANK;
                nxt_row = row + 1'b1;
                start   = !last_row;
            end
            default: nxt = enable ? S_FETCH : S_IDLE;
        endcase
    end

    led_dwell_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .load_val (load_val),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            row     <= '0;
            fcnt    <= '0;
            led_row <= '0;
            led_col <= '0;
            for (int i = 0; i < ROWS; i++) shadow[i] <= '0;
        end else begin
            state   <= nxt;
            row     <= nxt_row;
            fcnt    <= fetch_busy ? fcnt + 1'b1 : '0;
            for (int i = 0; i < ROWS; i++)
                if (fetch_busy && fcnt == FW'(i + RD_LAT)) shadow[i] <= mem_rd_data;
            led_row <= nxt == S_DWELL ? ROWS'(1) << nxt_row : '0;
            led_col <= nxt == S_DWELL ? shadow[nxt_row] : '0;
        end
    end
endmodule

// File: tb/tb_led_frame_reader.sv
// tb_led_frame_reader: scoreboard bench with a behavioural 4x10 memory (RD_LAT=1), DWELL=4, BLANK=2.
module tb_led_frame_reader;
    localparam int DWELL = 4;
    localparam int BLANK = 2;

    logic       clk = 0;
    logic       rst, enable;
    logic [9:0] mem_rd_data;
    logic [1:0] addr_rd;
    logic       fetch_busy, frame_done;
    logic [3:0] led_row;
    logic [9:0] led_col;
    logic [9:0] mem [4];

    int checks = 0, errors = 0;
    int cyc = 0, done_cnt = 0, last_done = -1, per_cnt = 0, run = 0, d0;
    bit mon_on = 0, abort = 0, per_on = 0;
    logic [3:0]  prev_row = '0;
    logic [9:0]  cur_col;
    logic [13:0] sb [$];
    logic [13:0] e;

    led_frame_reader #(.WIDTH(10), .ROWS(4), .RD_LAT(1), .DWELL(DWELL), .BLANK(BLANK)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .mem_rd_data (mem_rd_data),
        .addr_rd     (addr_rd),
        .fetch_busy  (fetch_busy),
        .led_row     (led_row),
        .led_col     (led_col),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) mem_rd_data <= mem[addr_rd];
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_frame(input logic [9:0] c0, c1, c2, c3);
        sb.push_back({4'b0001, c0});
        sb.push_back({4'b0010, c1});
        sb.push_back({4'b0100, c2});
        sb.push_back({4'b1000, c3});
    endtask

    task automatic wait_done(input int target, input int bound);
        for (int i = 0; i < bound && done_cnt < target; i++) step(1);
        check("wait_done", done_cnt, target);
    endtask

    // Scoreboard monitor: every lit row must match the next queued expectation.
    always @(negedge clk) if (mon_on) begin
        check("onehot", {31'b0, $onehot0(led_row)}, 1);
        if (led_row == '0) check("dark_col", led_col, 0);
        if (led_row != prev_row) begin
            if (prev_row != '0 && !abort) check("dwell_len", run, DWELL);
            if (led_row != '0) begin
                if (sb.size() == 0) check("sb_empty", 0, 1);
                else begin
                    e = sb.pop_front();
                    check("sb_row", led_row, e[13:10]);
                    check("sb_col", led_col, e[9:0]);
                end
                cur_col = led_col;
            end
            run = 1;
        end else begin
            run++;
            if (led_row != '0) check("col_hold", led_col, cur_col);
        end
        if (frame_done) begin
            done_cnt++;
            check("done_dark", led_row, 0);
            if (per_on && last_done >= 0) begin
                check("period", cyc - last_done, 30);
                per_cnt++;
            end
            last_done = cyc;
        end
        prev_row = led_row;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        enable = 0;
        for (int i = 0; i < 4; i++) mem[i] = '0;
        step(2);
        check("rst_addr", addr_rd, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_row", led_row, 0);
        check("rst_col", led_col, 0);
        check("rst_done", frame_done, 0);
        rst = 0;
        mon_on = 1;
        step(50);
        check("idle_done_cnt", done_cnt, 0);
        check("idle_row", led_row, 0);
        check("idle_busy", fetch_busy, 0);

        mem[0] = 10'h002; mem[1] = 10'h008; mem[2] = 10'h020; mem[3] = 10'h100;
        push_frame(10'h002, 10'h008, 10'h020, 10'h100);
        enable = 1;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("fetch_addr", addr_rd, k < 4 ? k - 1 : 3);
            check("fetch_busy", fetch_busy, 1);
        end
        step(1);
        check("c6_busy", fetch_busy, 0);
        check("c6_row", led_row, 0);
        step(1);
        check("c7_row", led_row, 0);
        step(1);
        check("c8_row", led_row, 4'b0001);
        check("c8_col", led_col, 10'h002);
        step(7);
        mem[2] = 10'h3FF;
        push_frame(10'h002, 10'h008, 10'h3FF, 10'h100);
        step(14);
        check("c29_done", frame_done, 0);
        step(1);
        check("c30_done", frame_done, 1);
        step(1);
        check("c31_busy", fetch_busy, 1);
        check("c31_addr", addr_rd, 0);

        step(14);
        enable = 0;
        d0 = done_cnt;
        step(15);
        check("c60_done", frame_done, 1);
        step(1);
        check("c61_busy", fetch_busy, 0);
        step(30);
        check("drop_done_once", done_cnt, d0 + 1);
        check("drop_dark", led_row, 0);
        check("drop_idle", fetch_busy, 0);

        enable = 1;
        sb.push_back({4'b0001, 10'h002});
        sb.push_back({4'b0010, 10'h008});
        sb.push_back({4'b0100, 10'h3FF});
        step(21);
        rst = 1;
        abort = 1;
        step(1);
        check("abort_row", led_row, 0);
        check("abort_col", led_col, 0);
        check("abort_busy", fetch_busy, 0);
        check("abort_done", frame_done, 0);
        check("abort_addr", addr_rd, 0);
        rst = 0;
        for (int f = 0; f < 3; f++) push_frame(10'h002, 10'h008, 10'h3FF, 10'h100);
        per_on = 1;
        last_done = -1;
        d0 = done_cnt;
        step(1);
        check("restart_busy", fetch_busy, 1);
        check("restart_addr", addr_rd, 0);
        abort = 0;

        wait_done(d0 + 2, 100);
        enable = 0;
        wait_done(d0 + 3, 100);
        step(10);
        check("end_row", led_row, 0);
        check("end_busy", fetch_busy, 0);
        check("period_seen", per_cnt, 2);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
